divider_period_meter: RTL and testbench

Measures the half-period of a slow toggling input in `clk_in` cycles and reports it as the equivalent divider load value, the inverse of the variable divider. Sits at the receiving end of a divided clock or toggle line, e.g. to recover a remote divider setting or to monitor a generated clock. Results are delivered over a valid/ready interface, with overrun and stall reporting.

---
 rtl/divider_period_meter.sv | 176 +++++++++++++++++
 tb/tb_divider_period_meter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_period_meter.sv
// divider_period_meter: measures the half-period of sig_in in clk_in cycles and reports it as a divider load.
// Optional 2-cycle glitch filter after the synchronizer: define DIVIDER_PERIOD_METER_FILTER_EN.
module divider_period_meter #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] meas_load,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             stalled
);

  typedef enum logic [1:0] {
    ST_ARM = 2'd0,
    ST_RUN = 2'd1,
    ST_OVF = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_c;
  logic                   lvl_q, lvl_d;
  logic                   edge_q, edge_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       meas_load_q, meas_load_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   stalled_q, stalled_d;
  logic                   capture_c;
  logic                   accept_c;

  // Metastability chain for the asynchronous input
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  end

`ifdef DIVIDER_PERIOD_METER_FILTER_EN
  logic cand_q, cand_d;
  logic filt_q, filt_d;

  // A level is accepted only once it has been seen on two consecutive cycles
  always_comb begin
    cand_d = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    if (cand_q == sync_q[SYNC_STAGES-1]) begin
      filt_d = cand_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      filt_q <= filt_d;
    end
  end

  always_comb begin
    level_c = filt_q;
  end
`else
  always_comb begin
    level_c = sync_q[SYNC_STAGES-1];
  end
`endif

  // Edge flag is registered so both polarities mark the same cycle for counter and FSM
  always_comb begin
    lvl_d  = level_c;
    edge_d = level_c ^ lvl_q;
  end

  // Interval counter: cleared on each edge, saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (edge_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; OVF is entered as the counter lands on all-ones so that value is never reported
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARM: begin
        if (edge_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!edge_q && (cnt_q >= CNT_LAST)) begin
          state_d = ST_OVF;
        end
      end
      ST_OVF: begin
        if (edge_q) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // Result capture and valid/ready handshake
  always_comb begin
    capture_c    = (state_q == ST_RUN) && edge_q;
    accept_c     = meas_valid_q && meas_ready;
    stalled_d    = (state_d != ST_RUN);
    meas_load_d  = meas_load_q;
    meas_valid_d = meas_valid_q && !accept_c;
    overrun_d    = overrun_q && !accept_c;
    if (capture_c) begin
      meas_load_d  = cnt_q;
      meas_valid_d = 1'b1;
      if (meas_valid_q && !accept_c) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meas_load_q  <= '0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      stalled_q    <= 1'b1;
    end else begin
      meas_load_q  <= meas_load_d;
      meas_valid_q <= meas_valid_d;
      overrun_q    <= overrun_d;
      stalled_q    <= stalled_d;
    end
  end

  assign meas_load  = meas_load_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_divider_period_meter.sv
// Directed bench for divider_period_meter: toggle stimulus with an interval-based scoreboard.
module tb_divider_period_meter;

  localparam int unsigned W     = 8;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned P_MAX = (1 << W) - 1;
`ifdef DIVIDER_PERIOD_METER_FILTER_EN
  localparam int unsigned FILT_LAT  = 2;
  localparam int unsigned FAST_LOAD = 1;
`else
  localparam int unsigned FILT_LAT  = 0;
  localparam int unsigned FAST_LOAD = 0;
`endif

  logic         clk_in     = 1'b0;
  logic         rst_n      = 1'b0;
  logic         sig_in     = 1'b0;
  logic         meas_ready = 1'b0;
  logic [W-1:0] meas_load;
  logic         meas_valid;
  logic         overrun;
  logic         stalled;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned sb_q[$];
  bit          sb_en  = 1'b0;
  bit          armed  = 1'b0;
  int unsigned since  = 0;

  always #5 clk_in = ~clk_in;

  divider_period_meter #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .meas_load  (meas_load),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .overrun    (overrun),
    .stalled    (stalled)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // One clock; sampled at the falling edge, accepted results are matched against the scoreboard
  task automatic cycle();
    int unsigned exp_load;
    @(negedge clk_in);
    since++;
    if (sb_en && meas_valid && meas_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed meas_load=%0d required no result", meas_load);
      end
      if (sb_q.size() != 0) begin
        exp_load = sb_q.pop_front();
        check("meas_load", 32'(meas_load), exp_load);
        check("overrun_clear", 32'(overrun), 32'd0);
      end
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) cycle();
  endtask

  // An edge P cycles after the previous one yields load P-1; intervals past saturation re-arm instead
  task automatic toggle();
    if (sb_en && armed && (since <= P_MAX)) begin
      sb_q.push_back(since - 1);
    end
    armed  = 1'b1;
    since  = 0;
    sig_in = ~sig_in;
  endtask

  task automatic glitch();
`ifdef DIVIDER_PERIOD_METER_FILTER_EN
    sig_in = ~sig_in;
    cycle();
    sig_in = ~sig_in;
`else
    toggle();
    cycle();
    toggle();
`endif
  endtask

  task automatic drain(input string tag);
    wait_cycles(8);
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    sb_en      = 1'b0;
    meas_ready = 1'b0;
    sig_in     = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    armed = 1'b0;
    since = 0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned lat;

    // Reset values
    repeat (2) @(negedge clk_in);
    check("rst_load", 32'(meas_load), 32'd0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd1);

    // Load 5 stream, consumer always ready
    do_reset();
    meas_ready = 1'b1;
    sb_en      = 1'b1;
    toggle();
    wait_cycles(6);
    check("load5_stalled", 32'(stalled), 32'd0);
    for (int i = 0; i < 6; i++) begin
      toggle();
      wait_cycles(6);
    end
    drain("load5_drain");

    // Latency of first result, then fastest measurable interval
    do_reset();
    meas_ready = 1'b1;
    sb_en      = 1'b1;
    toggle();
    wait_cycles(FAST_LOAD + 1);
    toggle();
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!meas_valid && (lat < 20));
    // Edge k+S+1 after the sampling edge k is the (S+2)-th falling edge after the drive
    check("latency", lat, SYNC + 2 + FILT_LAT);
    for (int i = 0; i < 10; i++) begin
      toggle();
      wait_cycles(FAST_LOAD + 1);
    end
    drain("fast_drain");

    // Three results with no consumer: last one kept, overrun flagged
    do_reset();
    toggle();
    wait_cycles(4);
    toggle();
    wait_cycles(8);
    toggle();
    wait_cycles(8);
    toggle();
    wait_cycles(8);
    check("ovr_load", 32'(meas_load), 32'd7);
    check("ovr_valid", 32'(meas_valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    meas_ready = 1'b1;
    cycle();
    meas_ready = 1'b0;
    check("acc_valid", 32'(meas_valid), 32'd0);
    check("acc_overrun", 32'(overrun), 32'd0);

    // Saturation: constant input after arming reaches OVF with no result
    do_reset();
    meas_ready = 1'b1;
    sb_en      = 1'b1;
    toggle();
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (i == 4)   check("sat_run", 32'(stalled), 32'd0);
      if (i == 258) check("sat_cnt254", 32'(stalled), 32'd0);
      if (i == 259) check("sat_cnt255", 32'(stalled), 32'd1);
    end
    check("sat_hold", 32'(stalled), 32'd1);
    toggle();
    wait_cycles(10);
    toggle();
    drain("sat_rearm_drain");
    check("sat_rearm_stalled", 32'(stalled), 32'd0);

    // Asynchronous reset midway through an interval
    do_reset();
    toggle();
    wait_cycles(20);
    toggle();
    wait_cycles(10);
    check("mid_load", 32'(meas_load), 32'd19);
    check("mid_valid", 32'(meas_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_load", 32'(meas_load), 32'd0);
    check("mid_rst_valid", 32'(meas_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_stalled", 32'(stalled), 32'd1);
    sig_in = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    armed = 1'b0;
    since = 0;
    sb_q.delete();
    meas_ready = 1'b1;
    sb_en      = 1'b1;
    toggle();
    wait_cycles(10);
    check("post_rst_armed", 32'(stalled), 32'd0);
    toggle();
    drain("post_rst_drain");

    // One-cycle glitch inside a load-9 stream
    do_reset();
    meas_ready = 1'b1;
    sb_en      = 1'b1;
    toggle();
    wait_cycles(10);
    toggle();
    wait_cycles(10);
    toggle();
    wait_cycles(4);
    glitch();
    wait_cycles(5);
    toggle();
    wait_cycles(10);
    toggle();
    drain("glitch_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
